rv32_lsu: RTL and testbench
===========================

# rv32_lsu

Load/store unit directly downstream of the execute-stage ALU. It takes the ALU result as the effective address, together with rs2 store data and funct3, and runs one data-memory transaction over a req/gnt/rvalid bus. It aligns and sign/zero-extends load data and returns a one-cycle writeback response. Misaligned or illegal accesses are reported as an error response and never reach memory.

## Interface
Parameters:
- XPR_LEN, 32, register/data width (fixed at 32; byte-lane logic assumes 4 lanes)
- REG_ADDR_W, 5, destination register index width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  1  execute stage presents a memory op
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I size/sign code
- req_addr  in  XPR_LEN  effective address (ALU res)
- req_wdata  in  XPR_LEN  store data (rs2)
- req_rd  in  REG_ADDR_W  load destination register
- mem_req  out  1  bus request, held until granted
- mem_gnt  in  1  bus accepts request this cycle
- mem_addr  out  XPR_LEN  word address ({req_addr[31:2],2'b00})
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables
- mem_wdata  out  XPR_LEN  lane-aligned store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XPR_LEN  read data word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_wb  out  1  rsp_data must be written to rsp_rd (successful load)
- rsp_err  out  1  misaligned/illegal access; no memory effect
- rsp_rd  out  REG_ADDR_W  destination register
- rsp_data  out  XPR_LEN  extended load data, 0 for stores/errors

## Operation
- States: IDLE, REQ, WAIT, RSP. Transitions:
  - IDLE→REQ on accept (req_valid & req_ready) of a legal access.
  - IDLE→RSP on accept of an illegal access, with rsp_err set.
  - REQ→WAIT on mem_gnt for a load.
  - REQ→RSP on mem_gnt for a store.
  - WAIT→RSP on mem_rvalid.
  - RSP→IDLE unconditionally.
- On accept, latch addr[1:0], funct3, we, rd, and the computed be/wdata. Bus outputs are registered and stable while mem_req=1.
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Misaligned: a halfword access with addr[0]=1, or a word access with addr[1:0]≠0.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111, wdata=rs2.
- Loads drive be per size, as for stores, with mem_we=0.
- Load data: shift mem_rdata right by 8*addr[1:0], then sign- or zero-extend byte/half per funct3[2]. Latched on mem_rvalid.
- mem_rvalid outside WAIT is ignored. mem_gnt outside REQ is ignored.

## Timing
- Reset values: req_ready=1 (IDLE); mem_req, mem_we, rsp_valid, rsp_wb, rsp_err = 0; mem_addr, mem_be, mem_wdata, rsp_rd, rsp_data = 0.
- Accept at cycle T gives mem_req=1 at T+1. mem_req stays high through wait cycles until the cycle mem_gnt=1, and drops the next cycle.
- Store with gnt at T+1: rsp_valid at T+2. Minimum store latency is 2.
- Load with gnt at T+1 and rvalid at T+2: rsp_valid at T+3. Minimum load latency is 3.
- Illegal access accepted at T: rsp_valid & rsp_err at T+1, and no mem_req ever.
- rsp_valid lasts exactly one cycle. Writeback always accepts, so there is no backpressure.
- req_ready=0 from T+1 until the cycle after RSP. At most one transaction is in flight.
- Asynchronous reset mid-transaction (any state): return to IDLE and clear all outputs immediately. A late mem_rvalid arriving after reset is ignored.

## Test plan
- LW at 0x100, rdata=0xDEADBEEF, gnt immediate, rvalid next cycle → mem_addr=0x100, be=1111, rsp_valid at T+3, rsp_wb=1, rsp_data=0xDEADBEEF.
- LB at 0x203 and LBU at 0x203, rdata=0x80112233 → rsp_data 0xFFFFFF80 and 0x00000080 respectively. LH at 0x202 → 0xFFFF8011.
- SB at 0x41, rs2=0x000000A5, gnt delayed 3 cycles → mem_req held 4 cycles with stable be=0010 and wdata=0xA5A5A5A5. rsp_valid 1 cycle after gnt with rsp_wb=0.
- SW at 0x42, and funct3=011 → rsp_err=1 at T+1, mem_req never asserts, req_ready high again at T+2.
- Spurious mem_rvalid in IDLE and REQ → no rsp_valid, state unchanged.
- rst_n low while in WAIT, then rvalid after release → all outputs 0, req_ready=1, no rsp_valid. The next LW completes normally.

Source files
------------

// File: rtl/rv32_lsu.sv
// RV32I load/store unit: one req/gnt/rvalid data-memory transaction at a time,
// with byte-lane steering for stores and alignment/extension for loads.
module rv32_lsu #(
  parameter int XPR_LEN    = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [XPR_LEN-1:0]    req_addr,
  input  logic [XPR_LEN-1:0]    req_wdata,
  input  logic [REG_ADDR_W-1:0] req_rd,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [XPR_LEN-1:0]    mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [XPR_LEN-1:0]    mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [XPR_LEN-1:0]    mem_rdata,
  output logic                  rsp_valid,
  output logic                  rsp_wb,
  output logic                  rsp_err,
  output logic [REG_ADDR_W-1:0] rsp_rd,
  output logic [XPR_LEN-1:0]    rsp_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_e;

  state_e                state_q, state_d;
  logic [1:0]            addr_lo_q;
  logic [2:0]            funct3_q;
  logic                  we_q;
  logic                  err_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XPR_LEN-1:0]    mem_addr_q;
  logic [3:0]            mem_be_q;
  logic [XPR_LEN-1:0]    mem_wdata_q;
  logic [XPR_LEN-1:0]    rdata_q;

  logic                  accept;
  logic                  legal;
  logic [3:0]            be_d;
  logic [XPR_LEN-1:0]    wdata_d;
  logic [XPR_LEN-1:0]    shifted;
  logic [XPR_LEN-1:0]    load_ext;

  assign accept = req_valid && (state_q == S_IDLE);

  // Request decode: size from funct3[1:0]; funct3[2] (unsigned) exists only for LBU/LHU.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    legal   = 1'b0;
    be_d    = 4'b0000;
    wdata_d = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        legal   = 1'b1;
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        legal   = ~req_addr[0];
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        legal   = (req_addr[1:0] == 2'b00);
        be_d    = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
    if (req_funct3[2] && (req_we || req_funct3[1])) legal = 1'b0;
  end

  always_comb begin
    shifted  = mem_rdata >> {addr_lo_q, 3'b000};
    load_ext = shifted;
    case (funct3_q[1:0])
      2'b00:   load_ext = funct3_q[2] ? {{(XPR_LEN-8){1'b0}}, shifted[7:0]}
                                      : {{(XPR_LEN-8){shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = funct3_q[2] ? {{(XPR_LEN-16){1'b0}}, shifted[15:0]}
                                      : {{(XPR_LEN-16){shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = legal ? S_REQ : S_RSP;
      S_REQ:  if (mem_gnt) state_d = we_q ? S_RSP : S_WAIT;
      S_WAIT: if (mem_rvalid) state_d = S_RSP;
      S_RSP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus fields are captured only for legal requests, so they stay stable while mem_req is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_lo_q   <= '0;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= '0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      if (accept) begin
        addr_lo_q <= req_addr[1:0];
        funct3_q  <= req_funct3;
        we_q      <= req_we;
        err_q     <= ~legal;
        rd_q      <= req_rd;
        if (legal) begin
          mem_addr_q  <= {req_addr[XPR_LEN-1:2], 2'b00};
          mem_be_q    <= be_d;
          mem_wdata_q <= wdata_d;
        end
      end
      if ((state_q == S_WAIT) && mem_rvalid) rdata_q <= load_ext;
    end
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    mem_req   = (state_q == S_REQ);
    mem_we    = mem_req && we_q;
    mem_addr  = mem_addr_q;
    mem_be    = mem_be_q;
    mem_wdata = mem_wdata_q;
    rsp_valid = (state_q == S_RSP);
    rsp_err   = rsp_valid && err_q;
    rsp_wb    = rsp_valid && !err_q && !we_q;
    rsp_rd    = rd_q;
    rsp_data  = rsp_wb ? rdata_q : '0;
  end

endmodule

// File: tb/tb_rv32_lsu.sv
// Self-checking bench for rv32_lsu: directed cases plus randomized transactions
// compared against an arithmetic reference model of RV32I load/store semantics.
module tb_rv32_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_wb, rsp_err;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;

  int checks = 0;
  int errors = 0;

  rv32_lsu #(.XPR_LEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_wb(rsp_wb), .rsp_err(rsp_err), .rsp_rd(rsp_rd),
    .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes and legality from the RV32I rules.
  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    if (f3[1:0] == 2'b11) return 0;
    if (f3[2] && (we || f3[1])) return 0;
    return (addr % nbytes(f3)) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    v = rdata >> (8 * (addr % 4));
    if (n < 4) begin
      v = v % (32'd1 << (8 * n));
      if (!f3[2] && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    end
    return v;
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_mreq"},  mem_req,   0);
    check({tag, "_mwe"},   mem_we,    0);
    check({tag, "_addr"},  mem_addr,  0);
    check({tag, "_be"},    mem_be,    0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_rspv"},  rsp_valid, 0);
    check({tag, "_wb"},    rsp_wb,    0);
    check({tag, "_err"},   rsp_err,   0);
    check({tag, "_rd"},    rsp_rd,    0);
    check({tag, "_data"},  rsp_data,  0);
  endtask

  // One full transaction; gd = cycles before gnt, rvd = cycles in WAIT before rvalid.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [4:0] rd, input int gd, input int rvd,
                     input logic [31:0] rdata, input logic [31:0] exp_data, input logic spur);
    int          n;
    bit          ok;
    logic [31:0] ebe, ewd;
    n   = nbytes(f3);
    ok  = model_legal(we, f3, addr);
    ebe = ((32'd1 << n) - 1) << (addr % 4);
    ewd = (n == 1) ? wdata[7:0] * 32'h0101_0101 : (n == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
    @(negedge clk);
    check("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    check("ready_busy", req_ready, 0);
    if (!ok) begin
      check("ill_rspv", rsp_valid, 1);
      check("ill_err",  rsp_err,   1);
      check("ill_wb",   rsp_wb,    0);
      check("ill_data", rsp_data,  0);
      check("ill_mreq", mem_req,   0);
      @(negedge clk);
      check("ill_ready2", req_ready, 1);
      check("ill_rspv2",  rsp_valid, 0);
      check("ill_mreq2",  mem_req,   0);
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      check("req_mreq", mem_req,   1);
      check("req_addr", mem_addr,  addr & 32'hFFFF_FFFC);
      check("req_be",   mem_be,    ebe);
      check("req_we",   mem_we,    we);
      if (we) check("req_wdata", mem_wdata, ewd);
      check("req_rspv", rsp_valid, 0);
      mem_gnt    = (i == gd);
      mem_rvalid = spur && (i < gd);
      mem_rdata  = $urandom;
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
    end
    check("post_gnt_mreq", mem_req, 0);
    if (we) begin
      check("st_rspv", rsp_valid, 1);
      check("st_wb",   rsp_wb,    0);
      check("st_err",  rsp_err,   0);
      check("st_data", rsp_data,  0);
    end else begin
      for (int i = 0; i < rvd; i++) begin
        check("wait_rspv", rsp_valid, 0);
        mem_gnt = 1'($urandom);
        @(negedge clk);
        mem_gnt = 1'b0;
      end
      check("wait_rspv_last", rsp_valid, 0);
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("ld_rspv", rsp_valid, 1);
      check("ld_wb",   rsp_wb,    1);
      check("ld_err",  rsp_err,   0);
      check("ld_rd",   rsp_rd,    rd);
      check("ld_data", rsp_data,  exp_data);
    end
    @(negedge clk);
    check("end_rspv",  rsp_valid, 0);
    check("end_ready", req_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; req_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1 check_cleared("reset");
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-computed expectations.
    txn(0, 3'b010, 32'h100, 0, 5'd1, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    txn(0, 3'b000, 32'h203, 0, 5'd2, 0, 1, 32'h8011_2233, 32'hFFFF_FF80, 0);
    txn(0, 3'b100, 32'h203, 0, 5'd3, 1, 0, 32'h8011_2233, 32'h0000_0080, 0);
    txn(0, 3'b001, 32'h202, 0, 5'd4, 0, 0, 32'h8011_2233, 32'hFFFF_8011, 0);
    txn(1, 3'b000, 32'h41, 32'h0000_00A5, 5'd5, 3, 0, 0, 0, 1);
    txn(1, 3'b010, 32'h42, 32'h1234_5678, 5'd6, 0, 0, 0, 0, 0);
    txn(0, 3'b011, 32'h40, 0, 5'd7, 0, 0, 0, 0, 0);
    txn(1, 3'b001, 32'h1002, 32'hCAFE_BABE, 5'd8, 1, 0, 0, 0, 0);

    // Spurious rvalid in IDLE must not produce a response.
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("spur_idle_rspv",  rsp_valid, 0);
    check("spur_idle_ready", req_ready, 1);
    check("spur_idle_mreq",  mem_req,   0);

    // Reset while waiting for read data; the late rvalid must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300; req_rd = 5'd9;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("pre_rst_mreq", mem_req, 0);
    rst_n = 1'b0;
    #1 check_cleared("rst_wait");
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rv_rspv",  rsp_valid, 0);
    check("late_rv_ready", req_ready, 1);
    check("late_rv_data",  rsp_data,  0);
    txn(0, 3'b010, 32'h304, 0, 5'd10, 0, 2, 32'h0123_4567, 32'h0123_4567, 0);

    // Randomized transactions against the reference model.
    for (int k = 0; k < 60; k++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, rdata;
      we    = 1'($urandom);
      f3    = 3'($urandom);
      if (($urandom % 4) != 0) f3 = we ? 3'($urandom % 3) : ((($urandom % 5) < 3) ? 3'($urandom % 3)
                                                              : 3'(4 + $urandom % 2));
      addr  = $urandom;
      wdata = $urandom;
      rdata = $urandom;
      txn(we, f3, addr, wdata, 5'($urandom), int'($urandom % 4), int'($urandom % 4), rdata,
          model_load(f3, addr, rdata), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
